// File: rtl/ram_dma.sv
// ram_dma: word-granular RAM initiator that copies a block of words from a
// source region to a destination region, or fills a destination region with a
// constant pattern. Every output is a register, so each RAM access appears one
// clock after the decision that launches it.
module ram_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [31:0]      src_i,
  input  logic [31:0]      dst_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      pattern_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic [3:0]       mem_sel_o,
  output logic             mem_we_o,
  input  logic [31:0]      mem_data_i
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

  localparam logic [LEN_W-1:0] LastWord = LEN_W'(1);

  state_t           state;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      pattern_q;
  logic [LEN_W-1:0] remain_q;
  logic             mode_q;

  // Command sequencer: the state and all registered RAM/handshake outputs.
  // The write-data register doubles as the copy word buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset is synchronous, so the datapath registers are cleared
      // here too; a reset mid-transfer must leave nothing to resume.
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      pattern_q  <= '0;
      remain_q   <= '0;
      mode_q     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      mem_sel_o  <= '0;
      mem_we_o   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; these idle defaults are
      // overridden below by whichever state launches the next access.
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      mem_sel_o  <= '0;
      mem_we_o   <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            src_q     <= src_i;
            dst_q     <= dst_i;
            remain_q  <= len_i;
            mode_q    <= mode_i;
            pattern_q <= pattern_i;
            err_o     <= 1'b0;
            if ((!mode_i && src_i[1:0] != 2'b00) || dst_i[1:0] != 2'b00) begin
              err_o  <= 1'b1;
              done_o <= 1'b1;
              state  <= FIN;
            end else if (len_i == '0) begin
              done_o <= 1'b1;
              state  <= FIN;
            end else if (mode_i) begin
              busy_o     <= 1'b1;
              mem_addr_o <= dst_i;
              mem_data_o <= pattern_i;
              mem_sel_o  <= 4'b1111;
              mem_we_o   <= 1'b1;
              state      <= WR;
            end else begin
              busy_o     <= 1'b1;
              mem_addr_o <= src_i;
              mem_sel_o  <= 4'b1111;
              state      <= RD;
            end
          end
        end

        RD: begin
          busy_o <= 1'b1;
          state  <= CAP;
        end

        CAP: begin
          busy_o     <= 1'b1;
          mem_addr_o <= dst_q;
          mem_data_o <= mem_data_i;
          mem_sel_o  <= 4'b1111;
          mem_we_o   <= 1'b1;
          state      <= WR;
        end

        WR: begin
          remain_q <= remain_q - LastWord;
          src_q    <= src_q + 32'd4;
          dst_q    <= dst_q + 32'd4;
          if (remain_q == LastWord) begin
            done_o <= 1'b1;
            state  <= FIN;
          end else if (mode_q) begin
            busy_o     <= 1'b1;
            mem_addr_o <= dst_q + 32'd4;
            mem_data_o <= pattern_q;
            mem_sel_o  <= 4'b1111;
            mem_we_o   <= 1'b1;
            state      <= WR;
          end else begin
            busy_o     <= 1'b1;
            mem_addr_o <= src_q + 32'd4;
            mem_sel_o  <= 4'b1111;
            state      <= RD;
          end
        end

        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
